// File: rtl/pet2001ps2kbd.sv
// PS/2 keyboard front end for the PET: receives scancode frames and maintains the
// 10x8 key matrix that PIA1 scans through keyrow/keyin.
module pet2001ps2kbd #(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [3:0] keyrow,
    output logic [7:0] keyin,
    output logic       frame_err
);
    localparam int unsigned FW = $clog2(FILTER + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {StIdle, StShift} rx_state_e;

    logic [1:0]       pclk_sync_q, pdat_sync_q;
    logic             filt_clk_q, filt_clk_d;
    logic [FW-1:0]    filt_cnt_q, filt_cnt_d;
    logic             sample, sample_bit;
    rx_state_e        state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [8:0]       shreg_q, shreg_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             byte_rdy_q, byte_rdy_d;
    logic [7:0]       code_q, code_d;
    logic             frame_err_q, frame_err_d;
    logic             ext_q, ext_d, brk_q, brk_d;
    logic [2:0]       skip_q, skip_d;
    logic [9:0][7:0]  matrix_q, matrix_d;
    logic             km_valid;
    logic [3:0]       km_row;
    logic [2:0]       km_col;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pclk_sync_q <= 2'b11;
            pdat_sync_q <= 2'b11;
            filt_clk_q  <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            tmo_q       <= '0;
            byte_rdy_q  <= 1'b0;
            code_q      <= '0;
            frame_err_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            skip_q      <= '0;
            matrix_q    <= '0;
        end else begin
            pclk_sync_q <= {pclk_sync_q[0], ps2_clk};
            pdat_sync_q <= {pdat_sync_q[0], ps2_data};
            filt_clk_q  <= filt_clk_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            tmo_q       <= tmo_d;
            byte_rdy_q  <= byte_rdy_d;
            code_q      <= code_d;
            frame_err_q <= frame_err_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            skip_q      <= skip_d;
            matrix_q    <= matrix_d;
        end
    end

    // The filtered clock follows the synchronized level only after FILTER stable cycles.
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (pclk_sync_q[1] != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER - 1)) begin
                filt_clk_d = pclk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign sample     = filt_clk_q & ~filt_clk_d;
    assign sample_bit = pdat_sync_q[1];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        tmo_d       = tmo_q;
        code_d      = code_q;
        byte_rdy_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            StIdle: begin
                tmo_d = '0;
                if (sample && !sample_bit) begin
                    state_d   = StShift;
                    bit_cnt_d = '0;
                end
            end
            StShift: begin
                if (sample) begin
                    tmo_d = '0;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = StIdle;
                        if ((^shreg_q) && sample_bit) begin
                            byte_rdy_d = 1'b1;
                            code_d     = shreg_q[7:0];
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        // Shift in from the top so the first data bit ends up at bit 0.
                        shreg_d   = {sample_bit, shreg_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d     = StIdle;
                    frame_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        km_valid = 1'b1;
        km_row   = 4'd0;
        km_col   = 3'd0;
        case ({ext_q, code_q})
            9'h01C:  begin km_row = 4'd4; km_col = 3'd0; end
            9'h029:  begin km_row = 4'd9; km_col = 3'd2; end
            9'h05A:  begin km_row = 4'd6; km_col = 3'd5; end
            9'h012:  begin km_row = 4'd8; km_col = 3'd0; end
            9'h059:  begin km_row = 4'd8; km_col = 3'd5; end
            9'h172:  begin km_row = 4'd1; km_col = 3'd7; end
            default: km_valid = 1'b0;
        endcase
    end

    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        skip_d   = skip_q;
        matrix_d = matrix_q;
        if (byte_rdy_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (code_q == 8'hE1) begin
                // Pause sends seven more bytes with no release semantics; swallow them.
                skip_d = 3'd7;
            end else if (code_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (code_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (!ext_q && !brk_q && code_q == 8'h07) begin
                    matrix_d = '0;
                end else if (km_valid) begin
                    matrix_d[km_row][km_col] = ~brk_q;
                end
            end
        end
    end

    assign keyin     = (keyrow <= 4'd9) ? ~matrix_q[keyrow] : 8'hFF;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_pet2001ps2kbd.sv
// Self-checking bench for pet2001ps2kbd: directed table, timing corner sequences and a
// randomized scancode stream compared against a key-event reference model.
module tb_pet2001ps2kbd;
    localparam int unsigned FILTER  = 8;
    localparam int unsigned TIMEOUT = 2000;
    localparam int HALF = 30;
    localparam int GAP  = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] keyrow = 4'd0;
    logic [7:0] keyin;
    logic       frame_err;

    int n_total = 0;
    int n_bad   = 0;
    int err_cnt = 0;

    pet2001ps2kbd #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keyrow    (keyrow),
        .keyin     (keyin),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_err === 1'b1) err_cnt++;

    typedef struct {
        bit         ext;
        logic [7:0] code;
        int         row;
        int         col;
    } key_t;
    key_t keys[6] = '{
        '{1'b0, 8'h1C, 4, 0}, '{1'b0, 8'h29, 9, 2}, '{1'b0, 8'h5A, 6, 5},
        '{1'b0, 8'h12, 8, 0}, '{1'b0, 8'h59, 8, 5}, '{1'b1, 8'h72, 1, 7}
    };

    // Reference model: set of pressed (row,col) positions plus prefix state.
    bit m_pressed[10][8];
    bit m_ext, m_brk;
    int m_skip;

    task automatic model_reset();
        foreach (m_pressed[r, c]) m_pressed[r][c] = 1'b0;
        m_ext = 0; m_brk = 0; m_skip = 0;
    endtask

    task automatic model_byte(input logic [7:0] c);
        if (m_skip > 0) m_skip--;
        else if (c == 8'hE1) m_skip = 7;
        else if (c == 8'hE0) m_ext = 1;
        else if (c == 8'hF0) m_brk = 1;
        else begin
            if (!m_ext && !m_brk && c == 8'h07) begin
                foreach (m_pressed[r, k]) m_pressed[r][k] = 1'b0;
            end else begin
                foreach (keys[i])
                    if (keys[i].ext == m_ext && keys[i].code == c)
                        m_pressed[keys[i].row][keys[i].col] = !m_brk;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    function automatic logic [7:0] model_keyin(input int row);
        logic [7:0] v = 8'hFF;
        if (row <= 9) for (int k = 0; k < 8; k++) if (m_pressed[row][k]) v[k] = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int lo, input int hi);
        n_total++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic read_row(input int row, output logic [7:0] v);
        @(negedge clk);
        keyrow = 4'(row);
        #1 v = keyin;
    endtask

    task automatic send_frame(input logic [7:0] c, input bit corrupt, input int nbits,
                              input int gap);
        logic [10:0] f;
        f = {1'b1, (~^c) ^ corrupt, c, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] c, input bit corrupt);
        send_frame(c, corrupt, 11, GAP);
        if (!corrupt) model_byte(c);
    endtask

    typedef struct {
        bit         do_send;
        logic [7:0] code;
        bit         corrupt;
        int         row;
        logic [7:0] exp;
        int         errs;
    } vec_t;
    vec_t vt[$];

    initial begin
        logic [7:0] v;
        int e0, n;
        bit seen;

        model_reset();
        repeat (3) @(negedge clk);
        foreach (keys[i]) begin
            read_row(keys[i].row, v);
            check("reset_keyin", v, 8'hFF);
        end
        check("reset_frame_err", {7'd0, frame_err}, 8'h00);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        vt.push_back('{1, 8'h1C, 0, 4, 8'hFE, 0});
        vt.push_back('{0, 8'h00, 0, 5, 8'hFF, 0});
        vt.push_back('{1, 8'hF0, 0, 4, 8'hFE, 0});
        vt.push_back('{1, 8'h1C, 0, 4, 8'hFF, 0});
        vt.push_back('{0, 8'h00, 0, 5, 8'hFF, 0});
        vt.push_back('{1, 8'hE0, 0, 1, 8'hFF, 0});
        vt.push_back('{1, 8'h72, 0, 1, 8'h7F, 0});
        vt.push_back('{1, 8'h12, 0, 8, 8'hFE, 0});
        vt.push_back('{0, 8'h00, 0, 1, 8'h7F, 0});
        vt.push_back('{1, 8'hE0, 0, 1, 8'h7F, 0});
        vt.push_back('{1, 8'hF0, 0, 1, 8'h7F, 0});
        vt.push_back('{1, 8'h72, 0, 1, 8'hFF, 0});
        vt.push_back('{0, 8'h00, 0, 8, 8'hFE, 0});
        vt.push_back('{1, 8'h29, 1, 9, 8'hFF, 1});
        vt.push_back('{1, 8'h29, 0, 9, 8'hFB, 0});
        for (int r = 10; r < 16; r++) vt.push_back('{0, 8'h00, 0, r, 8'hFF, 0});

        foreach (vt[i]) begin
            e0 = err_cnt;
            if (vt[i].do_send) send(vt[i].code, vt[i].corrupt);
            read_row(vt[i].row, v);
            check($sformatf("vec%0d_keyin", i), v, vt[i].exp);
            check_int($sformatf("vec%0d_frame_err", i), err_cnt - e0, vt[i].errs, vt[i].errs);
        end

        // Timeout: four bits then the clock stops.
        e0 = err_cnt;
        send_frame(8'hA5, 0, 4, 0);
        n = HALF;
        seen = 0;
        while (!seen && n < int'(TIMEOUT + FILTER) + 100) begin
            @(negedge clk);
            n++;
            if (frame_err === 1'b1) seen = 1;
        end
        check_int("timeout_latency", n, int'(TIMEOUT + FILTER), int'(TIMEOUT + FILTER) + 4);
        repeat (5) @(negedge clk);
        check_int("timeout_pulses", err_cnt - e0, 1, 1);

        // Short low glitch with data low must not start a frame.
        e0 = err_cnt;
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (50) @(negedge clk);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        send(8'h59, 0);
        read_row(8, v);
        check("glitch_then_rshift", v, 8'hDE);
        check_int("glitch_frame_err", err_cnt - e0, 0, 0);

        // Reset in the middle of a frame.
        send(8'h5A, 0);
        read_row(6, v);
        check("row6_return", v, 8'hDF);
        send_frame(8'h1C, 0, 5, 0);
        @(negedge clk);
        reset_n = 1'b0;
        for (int r = 0; r < 16; r++) begin
            keyrow = 4'(r);
            #1 check($sformatf("midreset_row%0d", r), keyin, 8'hFF);
        end
        check("midreset_frame_err", {7'd0, frame_err}, 8'h00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        send(8'h1C, 0);
        send(8'h29, 0);
        read_row(4, v);
        check("repress_row4", v, 8'hFE);
        read_row(9, v);
        check("repress_row9", v, 8'hFB);
        send(8'h07, 0);
        read_row(4, v);
        check("f12_row4", v, 8'hFF);
        read_row(9, v);
        check("f12_row9", v, 8'hFF);

        // Randomized scancode stream against the reference model.
        begin
            logic [7:0] pool[11] = '{8'h1C, 8'h29, 8'h5A, 8'h12, 8'h59, 8'h72,
                                     8'hE0, 8'hF0, 8'h07, 8'hE1, 8'h00};
            logic [7:0] c;
            bit corrupt;
            int row;
            for (int i = 0; i < 45; i++) begin
                c = pool[$urandom_range(0, 10)];
                if (c == 8'h00) c = 8'($urandom_range(0, 255));
                // Bias towards F0 so releases follow presses often.
                if ($urandom_range(0, 4) == 0) c = 8'hF0;
                corrupt = ($urandom_range(0, 7) == 0);
                e0 = err_cnt;
                send(c, corrupt);
                row = $urandom_range(0, 15);
                read_row(row, v);
                check($sformatf("rand%0d_row%0d", i, row), v, model_keyin(row));
                check_int($sformatf("rand%0d_frame_err", i), err_cnt - e0,
                          int'(corrupt), int'(corrupt));
            end
            for (int r = 0; r < 16; r++) begin
                read_row(r, v);
                check($sformatf("final_row%0d", r), v, model_keyin(r));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #50ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
